// File: rtl/run_detect_scheduler_pkg.sv
// run_sched_pkg
// Shared definitions for the run-length detect scheduler slice:
//   - state_t       : scheduler FSM encoding (IDLE, SHIFT, DONE)
//   - DEF_WORD_W    : default requester word width
//   - DEF_RUN_LEN   : default number of equal bits that form a match
//   - DEF_CNT_W     : default width of the per-job hit count
//   - REQ0 / REQ1   : requester identifiers as carried on o_done_id
package run_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int DEF_WORD_W  = 8;
   localparam int DEF_RUN_LEN = 4;
   localparam int DEF_CNT_W   = 4;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/run_detect_scheduler_if.sv
// run_detect_scheduler_if
// Bundles the requester handshake and the job-result signals of the scheduler.
//   i_req[1:0]   : per-requester request, held until the matching grant bit
//   i_data0/1    : requester words, stable while the request is high
//   o_gnt[1:0]   : one-hot, one-cycle grant pulse (word captured)
//   o_busy       : job in progress
//   o_serial     : bit currently presented to the detector
//   o_match      : registered detector result for the last processed bit
//   o_done       : one-cycle job-complete pulse
//   o_done_id    : requester served by the completed job
//   o_hits       : match count of the last completed job
// Modports: master = requester/lab side, slave = scheduler side.
interface run_detect_scheduler_if
   import run_sched_pkg::*;
#(
   parameter int WORD_W = DEF_WORD_W,
   parameter int CNT_W  = DEF_CNT_W
) ();

   logic [1:0]        i_req;
   logic [WORD_W-1:0] i_data0;
   logic [WORD_W-1:0] i_data1;
   logic [1:0]        o_gnt;
   logic              o_busy;
   logic              o_serial;
   logic              o_match;
   logic              o_done;
   logic              o_done_id;
   logic [CNT_W-1:0]  o_hits;

   modport master (
      output i_req, i_data0, i_data1,
      input  o_gnt, o_busy, o_serial, o_match, o_done, o_done_id, o_hits
   );

   modport slave (
      input  i_req, i_data0, i_data1,
      output o_gnt, o_busy, o_serial, o_match, o_done, o_done_id, o_hits
   );

endinterface

// File: rtl/run_detect_scheduler_len_detector.sv
// run_len_detector
// Serial detector for runs of RUN_LEN equal bits (all 0s or all 1s).
//   i_clk    : clock, rising edge
//   i_reset  : synchronous active-low reset
//   i_clear  : start of a new word; forgets the previous bit and the run
//   i_valid  : i_bit is a real data bit this cycle
//   i_bit    : serial data bit
//   o_match  : registered, high when the last processed bit completed a run
//   o_rc     : saturating run counter (0 means no bit seen yet in this word)
module run_len_detector #(
   parameter int RUN_LEN = 4,
   parameter int RC_W    = $clog2(RUN_LEN + 1)
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_clear,
   input  logic            i_valid,
   input  logic            i_bit,
   output logic            o_match,
   output logic [RC_W-1:0] o_rc
);

   logic [RC_W-1:0] r_rc;
   logic [RC_W-1:0] w_rcNext;
   logic            r_prev;
   logic            r_match;

   // Next run length. A zero counter marks the first bit of a word, so it
   // starts a fresh run. The counter parks at RUN_LEN so every further equal
   // bit of a long run is reported as another match.
   always_comb begin
      w_rcNext = RC_W'(1);
      if (r_rc != '0 && i_bit == r_prev) begin
         if (r_rc == RC_W'(RUN_LEN)) begin
            w_rcNext = r_rc;
         end else begin
            w_rcNext = r_rc + RC_W'(1);
         end
      end
   end

   // Run state and the registered match flag.
   always_ff @(posedge i_clk) begin
      if (!i_reset || i_clear) begin
         r_rc    <= '0;
         r_prev  <= 1'b0;
         r_match <= 1'b0;
      end else if (i_valid) begin
         r_rc    <= w_rcNext;
         r_prev  <= i_bit;
         r_match <= (w_rcNext == RC_W'(RUN_LEN));
      end
   end

   assign o_match = r_match;
   assign o_rc    = r_rc;

endmodule

// File: rtl/run_detect_scheduler.sv
// run_detect_scheduler
// Shares one serial run-length detector between two requesters. A round-robin
// arbiter grants one requester, its word is shifted MSB-first into the
// detector, matches are counted, and a one-cycle done pulse returns the count
// and the served requester.
//   i_clk   : clock, rising edge
//   i_reset : synchronous active-low reset
//   bus     : run_detect_scheduler_if slave (requests, words, grant, results)
module run_detect_scheduler
   import run_sched_pkg::*;
#(
   parameter int WORD_W  = DEF_WORD_W,
   parameter int RUN_LEN = DEF_RUN_LEN,
   parameter int CNT_W   = DEF_CNT_W
) (
   input logic                   i_clk,
   input logic                   i_reset,
   run_detect_scheduler_if.slave bus
);

   localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam int RC_W  = $clog2(RUN_LEN + 1);

   state_t            r_state;
   state_t            w_nextState;
   logic              w_grant;
   logic              w_winner;
   logic              w_lastBit;
   logic              w_serial;
   logic              w_runHit;
   logic              w_detMatch;
   logic [RC_W-1:0]   w_rc;
   logic [CNT_W-1:0]  w_hitsFinal;

   logic [WORD_W-1:0] r_shiftReg;
   logic [IDX_W-1:0]  r_bitIdx;
   logic [CNT_W-1:0]  r_hits;
   logic [CNT_W-1:0]  r_hitsOut;
   logic              r_rrLast;
   logic              r_doneId;
   logic [1:0]        r_gnt;

   // Round-robin choice: a lone request wins outright, a tie goes to the
   // requester that was not served last.
   always_comb begin
      w_winner = REQ1;
      if (bus.i_req[0]) begin
         w_winner = bus.i_req[1] ? ~r_rrLast : REQ0;
      end
   end

   assign w_lastBit = (r_bitIdx == '0);
   assign w_serial  = (r_state == SHIFT) ? r_shiftReg[r_bitIdx] : 1'b0;

   // A saturated run counter means the bit processed on the previous edge was
   // a match. It is the same event o_match reports, so the hit count and the
   // monitor output can never disagree.
   assign w_runHit    = (w_rc == RC_W'(RUN_LEN));
   assign w_hitsFinal = r_hits + CNT_W'(w_runHit);

   // FSM next-state logic; a grant can only be issued from IDLE.
   always_comb begin
      w_nextState = r_state;
      w_grant     = 1'b0;
      case (r_state)
         IDLE: begin
            if (|bus.i_req) begin
               w_grant     = 1'b1;
               w_nextState = SHIFT;
            end
         end
         SHIFT: begin
            if (w_lastBit) begin
               w_nextState = DONE;
            end
         end
         DONE: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Datapath: word capture, bit index, hit accumulation and result registers.
   // During SHIFT the counter picks up the match of the bit processed on the
   // previous edge; the last bit's match is folded in while in DONE, which is
   // why o_hits shows the live sum in DONE and the held copy afterwards.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_shiftReg <= '0;
         r_bitIdx   <= '0;
         r_hits     <= '0;
         r_hitsOut  <= '0;
         r_doneId   <= 1'b0;
         r_gnt      <= 2'b00;
         r_rrLast   <= REQ1;
      end else begin
         r_gnt <= 2'b00;
         if (w_grant) begin
            r_shiftReg <= w_winner ? bus.i_data1 : bus.i_data0;
            r_rrLast   <= w_winner;
            r_gnt      <= w_winner ? 2'b10 : 2'b01;
            r_bitIdx   <= IDX_W'(WORD_W - 1);
            r_hits     <= '0;
         end
         if (r_state == SHIFT) begin
            r_bitIdx <= r_bitIdx - IDX_W'(1);
            r_hits   <= w_hitsFinal;
            if (w_lastBit) begin
               r_doneId <= r_rrLast;
            end
         end
         if (r_state == DONE) begin
            r_hitsOut <= w_hitsFinal;
         end
      end
   end

   run_len_detector #(
      .RUN_LEN (RUN_LEN),
      .RC_W    (RC_W)
   ) u_detector (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_clear (w_grant || (r_state == DONE)),
      .i_valid (r_state == SHIFT),
      .i_bit   (w_serial),
      .o_match (w_detMatch),
      .o_rc    (w_rc)
   );

   assign bus.o_gnt     = r_gnt;
   assign bus.o_busy    = (r_state != IDLE);
   assign bus.o_serial  = w_serial;
   assign bus.o_match   = w_detMatch;
   assign bus.o_done    = (r_state == DONE);
   assign bus.o_done_id = r_doneId;
   assign bus.o_hits    = (r_state == DONE) ? w_hitsFinal : r_hitsOut;

endmodule

// File: tb/tb_run_detect_scheduler.sv
// tb_run_detect_scheduler
// Self-checking bench for run_detect_scheduler (WORD_W=8, RUN_LEN=4, CNT_W=4).
// Single-request jobs come from a vector table; round-robin, bit-level
// monitor, mid-job reset and requests-during-SHIFT are hand-written sequences.
// Expected job results go into a queue when a job is driven and are popped
// when o_done pulses.
module tb_run_detect_scheduler;

   typedef struct {
      logic [1:0] req;
      logic [7:0] data0;
      logic [7:0] data1;
      logic       expId;
      logic [3:0] expHits;
   } vec_t;

   typedef struct {
      logic       id;
      logic [3:0] hits;
   } exp_t;

   logic clk;
   logic resetN;
   int   checks;
   int   errors;
   exp_t expQ[$];
   vec_t vecs[9];

   run_detect_scheduler_if #(.WORD_W(8), .CNT_W(4)) bus ();

   run_detect_scheduler #(
      .WORD_W  (8),
      .RUN_LEN (4),
      .CNT_W   (4)
   ) dut (
      .i_clk   (clk),
      .i_reset (resetN),
      .bus     (bus)
   );

   // 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case a sequence loses track of the DUT.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkEq(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic waitGrant(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (bus.o_gnt == 2'b00 && cyc < 30);
   endtask

   task automatic waitDone(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (bus.o_done == 1'b0 && cyc < 30);
   endtask

   // Pops the next expected job result and compares it with the done outputs.
   task automatic checkOutput();
      exp_t e;
      checkEq("done pulse", int'(bus.o_done), 1);
      if (expQ.size() == 0) begin
         checkEq("scoreboard has entry", 0, 1);
      end else begin
         e = expQ.pop_front();
         checkEq("done_id", int'(bus.o_done_id), int'(e.id));
         checkEq("hits", int'(bus.o_hits), int'(e.hits));
      end
   endtask

   // Runs one table vector: request, grant latency, done latency, results and
   // the IDLE cycle after DONE.
   task automatic applyStimulus(input vec_t v);
      int cyc;
      @(negedge clk);
      bus.i_req   = v.req;
      bus.i_data0 = v.data0;
      bus.i_data1 = v.data1;
      expQ.push_back('{v.expId, v.expHits});
      waitGrant(cyc);
      checkEq("grant latency", cyc, 1);
      checkEq("grant", int'(bus.o_gnt), v.expId ? 2 : 1);
      checkEq("busy in SHIFT", int'(bus.o_busy), 1);
      bus.i_req = 2'b00;
      waitDone(cyc);
      checkEq("done latency", cyc, 8);
      checkOutput();
      @(negedge clk);
      checkEq("done cleared", int'(bus.o_done), 0);
      checkEq("busy cleared", int'(bus.o_busy), 0);
      checkEq("match cleared", int'(bus.o_match), 0);
      checkEq("hits held", int'(bus.o_hits), int'(v.expHits));
   endtask

   task automatic doReset();
      @(negedge clk);
      resetN = 1'b0;
      bus.i_req = 2'b00;
      repeat (2) @(negedge clk);
      resetN = 1'b1;
   endtask

   initial begin
      int  cyc;
      int  grants;
      int  dones;
      int  lastG;
      int  gntCyc;
      bit  expMatch[8];
      bit  expSerial[8];

      checks = 0;
      errors = 0;
      resetN = 1'b0;
      bus.i_req   = 2'b00;
      bus.i_data0 = 8'h00;
      bus.i_data1 = 8'h00;

      //            req     d0     d1     id    hits
      vecs[0] = '{2'b01, 8'h00, 8'h00, 1'b0, 4'd5};
      vecs[1] = '{2'b10, 8'h00, 8'h0F, 1'b1, 4'd2};
      vecs[2] = '{2'b01, 8'hE1, 8'h00, 1'b0, 4'd1};
      vecs[3] = '{2'b01, 8'h55, 8'h00, 1'b0, 4'd0};
      vecs[4] = '{2'b01, 8'hFE, 8'h00, 1'b0, 4'd4};
      vecs[5] = '{2'b10, 8'h00, 8'hFF, 1'b1, 4'd5};
      vecs[6] = '{2'b10, 8'h00, 8'h33, 1'b1, 4'd0};
      vecs[7] = '{2'b01, 8'hF0, 8'h00, 1'b0, 4'd2};
      vecs[8] = '{2'b01, 8'h71, 8'h00, 1'b0, 4'd0};

      expMatch  = '{0, 0, 0, 0, 0, 0, 1, 0};
      expSerial = '{1, 1, 1, 0, 0, 0, 0, 1};

      // Reset state.
      repeat (3) @(negedge clk);
      checkEq("reset gnt", int'(bus.o_gnt), 0);
      checkEq("reset busy", int'(bus.o_busy), 0);
      checkEq("reset done", int'(bus.o_done), 0);
      checkEq("reset hits", int'(bus.o_hits), 0);
      checkEq("reset done_id", int'(bus.o_done_id), 0);
      resetN = 1'b1;

      $display("[TB] table vectors");
      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i]);
      end

      // Bit-level view of 8'hE1: o_serial per SHIFT cycle, o_match one
      // cycle after each bit is processed.
      $display("[TB] serial/match trace on E1");
      @(negedge clk);
      bus.i_req   = 2'b01;
      bus.i_data0 = 8'hE1;
      expQ.push_back('{1'b0, 4'd1});
      waitGrant(cyc);
      checkEq("E1 grant", int'(bus.o_gnt), 1);
      bus.i_req = 2'b00;
      for (int k = 0; k < 8; k++) begin
         checkEq($sformatf("E1 serial bit%0d", k), int'(bus.o_serial), int'(expSerial[k]));
         @(negedge clk);
         checkEq($sformatf("E1 match bit%0d", k), int'(bus.o_match), int'(expMatch[k]));
      end
      checkOutput();

      // Round-robin with both requests held from reset.
      $display("[TB] round-robin with both requests held");
      doReset();
      bus.i_data0 = 8'h00;
      bus.i_data1 = 8'h0F;
      @(negedge clk);
      bus.i_req = 2'b11;
      grants = 0;
      dones  = 0;
      lastG  = 0;
      for (int c = 1; c <= 70; c++) begin
         @(negedge clk);
         if (bus.o_gnt != 2'b00) begin
            checkEq($sformatf("rr grant %0d", grants), int'(bus.o_gnt), (grants % 2 == 0) ? 1 : 2);
            if (grants > 0) begin
               checkEq("rr grant spacing", c - lastG, 10);
            end
            lastG = c;
            if (grants % 2 == 0) expQ.push_back('{1'b0, 4'd5});
            else                 expQ.push_back('{1'b1, 4'd2});
            grants++;
            if (grants == 4) bus.i_req = 2'b00;
         end
         if (bus.o_done) begin
            checkEq("no grant in DONE", int'(bus.o_gnt), 0);
            checkOutput();
            dones++;
         end
         if (dones == 4) break;
      end
      checkEq("rr grants seen", grants, 4);
      checkEq("rr dones seen", dones, 4);

      // Reset in SHIFT cycle 4 aborts the job; a tie afterwards goes to req 0.
      $display("[TB] reset during SHIFT");
      @(negedge clk);
      bus.i_req   = 2'b01;
      bus.i_data0 = 8'hFF;
      waitGrant(cyc);
      checkEq("abort job grant", int'(bus.o_gnt), 1);
      bus.i_req = 2'b00;
      repeat (4) @(negedge clk);
      resetN = 1'b0;
      @(negedge clk);
      checkEq("abort gnt", int'(bus.o_gnt), 0);
      checkEq("abort busy", int'(bus.o_busy), 0);
      checkEq("abort serial", int'(bus.o_serial), 0);
      checkEq("abort match", int'(bus.o_match), 0);
      checkEq("abort done", int'(bus.o_done), 0);
      checkEq("abort done_id", int'(bus.o_done_id), 0);
      checkEq("abort hits", int'(bus.o_hits), 0);
      resetN      = 1'b1;
      bus.i_data0 = 8'h00;
      bus.i_data1 = 8'h0F;
      bus.i_req   = 2'b11;
      expQ.push_back('{1'b0, 4'd5});
      waitGrant(cyc);
      checkEq("post-reset grant latency", cyc, 1);
      checkEq("post-reset tie grant", int'(bus.o_gnt), 1);
      checkEq("post-reset hits", int'(bus.o_hits), 0);
      bus.i_req = 2'b00;
      waitDone(cyc);
      checkEq("post-reset done latency", cyc, 8);
      checkOutput();

      // A request raised mid-SHIFT waits until the IDLE cycle after DONE.
      $display("[TB] request during SHIFT");
      @(negedge clk);
      bus.i_req   = 2'b01;
      bus.i_data0 = 8'h0F;
      expQ.push_back('{1'b0, 4'd2});
      waitGrant(cyc);
      checkEq("first job grant", int'(bus.o_gnt), 1);
      bus.i_req = 2'b00;
      repeat (2) @(negedge clk);
      bus.i_req   = 2'b10;
      bus.i_data1 = 8'h00;
      gntCyc = 0;
      for (int c = 3; c <= 20; c++) begin
         @(negedge clk);
         if (c == 3) begin
            checkEq("hits held during SHIFT", int'(bus.o_hits), 5);
         end
         if (bus.o_done) begin
            checkEq("first job done cycle", c, 8);
            checkOutput();
         end
         if (bus.o_gnt != 2'b00) begin
            gntCyc = c;
            break;
         end
      end
      checkEq("late grant cycle", gntCyc, 10);
      checkEq("late grant", int'(bus.o_gnt), 2);
      checkEq("hits held before new done", int'(bus.o_hits), 2);
      expQ.push_back('{1'b1, 4'd5});
      bus.i_req = 2'b00;
      waitDone(cyc);
      checkEq("late job done latency", cyc, 8);
      checkOutput();
      checkEq("scoreboard drained", expQ.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
